ps2_cmd_ctrl: RTL and testbench

Host-side command sequencer for the PS/2 transceiver (ps2_rxtx). It accepts command bytes from the system side and drives wr_ps2/din. It then waits for the device ACK (0xFA), retries on RESEND (0xFE) and times out on silence. All non-ACK/RESEND received bytes (scan codes, mouse packets, command replies) are buffered in a small FIFO for the system side.

---
 rtl/ps2_cmd_ctrl_if.sv | 49 ++++
 rtl/ps2_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_cmd_ctrl_if
//  Purpose  : Bundles the command, receive-FIFO and PS/2 transceiver signals
//             of the PS/2 host command sequencer.
//  Modports : slave  - the controller (ps2_cmd_ctrl)
//             master - the system side plus the ps2_rxtx transceiver
//  Signals  : cmd_valid/cmd_data/cmd_ready   command byte handshake
//             cmd_done/cmd_err/err_timeout   command completion status
//             rx_valid/rx_data/rx_ready      receive FIFO head (FWFT)
//             rx_overflow/clr_ovf            sticky drop flag and its clear
//             wr_ps2/ps2_din                 transmit strobe and byte
//             rx_done_tick/tx_done_tick      transceiver event ticks
//             ps2_dout                       received byte
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_cmd_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;
  logic       err_timeout;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overflow;
  logic       clr_ovf;
  logic       wr_ps2;
  logic [7:0] ps2_din;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] ps2_dout;

  modport slave (
    input  cmd_valid, cmd_data, rx_ready, clr_ovf,
           rx_done_tick, tx_done_tick, ps2_dout,
    output cmd_ready, cmd_done, cmd_err, err_timeout,
           rx_valid, rx_data, rx_overflow, wr_ps2, ps2_din
  );

  modport master (
    output cmd_valid, cmd_data, rx_ready, clr_ovf,
           rx_done_tick, tx_done_tick, ps2_dout,
    input  cmd_ready, cmd_done, cmd_err, err_timeout,
           rx_valid, rx_data, rx_overflow, wr_ps2, ps2_din
  );
endinterface
`default_nettype wire

// File: rtl/ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_cmd_ctrl
//  Purpose  : PS/2 host command sequencer. Sends a command byte through the
//             transceiver, waits for ACK (0xFA), retries on RESEND (0xFE),
//             times out on silence, and buffers every other received byte
//             in a first-word-fall-through FIFO.
//  Ports    : clk    - clock
//             rst_n  - synchronous reset, active low
//             bus    - ps2_cmd_ctrl_if.slave (command, FIFO, transceiver)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRY      = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  ps2_cmd_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);
  localparam logic [7:0]    C_ACK       = 8'hFA;
  localparam logic [7:0]    C_RESEND    = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_TX  = 2'd2,
    S_WAIT_RSP = 2'd3
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;
  logic          cmd_ready_q;
  logic          cmd_done_q;
  logic          cmd_err_q;
  logic          err_timeout_q;
  logic          wr_ps2_q;
  logic [7:0]    ps2_din_q;

  // Receive FIFO storage and pointers (one extra bit distinguishes full/empty)
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          ovf_q;

  logic          is_proto;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          wr_en;
  logic          ovf_d;

  // ACK/RESEND are consumed by the sequencer only while it awaits a response;
  // any other received byte, or any byte in another state, goes to the FIFO.
  assign is_proto = (state_q == S_WAIT_RSP) &&
                    ((bus.ps2_dout == C_ACK) || (bus.ps2_dout == C_RESEND));
  assign push     = bus.rx_done_tick && !is_proto;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Pop only on a visible head, so a pop against an empty FIFO is ignored
  assign pop   = !empty && bus.rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en = push && (!full || pop);
  // A new drop wins over a simultaneous clear
  assign ovf_d = (ovf_q && !bus.clr_ovf) || (push && full && !pop);

  // Command sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      retry_q       <= '0;
      cmd_ready_q   <= 1'b1;
      cmd_done_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      wr_ps2_q      <= 1'b0;
      ps2_din_q     <= 8'h00;
    end else begin
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_ps2_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            ps2_din_q     <= bus.cmd_data;
            err_timeout_q <= 1'b0;
            retry_q       <= '0;
            cmd_ready_q   <= 1'b0;
            wr_ps2_q      <= 1'b1;
            state_q       <= S_SEND;
          end
        end
        S_SEND: begin
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // The transmitter bounds this phase; no timeout here
          if (bus.tx_done_tick) begin
            timer_q <= '0;
            state_q <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          timer_q <= timer_q + 1'b1;
          // A byte arriving on the expiry cycle takes precedence
          if (bus.rx_done_tick) begin
            if (bus.ps2_dout == C_ACK) begin
              cmd_done_q  <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else if (bus.ps2_dout == C_RESEND) begin
              if (retry_q < C_MAX_RETRY) begin
                retry_q  <= retry_q + 1'b1;
                wr_ps2_q <= 1'b1;
                state_q  <= S_SEND;
              end else begin
                cmd_err_q   <= 1'b1;
                cmd_ready_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end else begin
              timer_q <= '0;
            end
          end else if (timer_q == C_TMO_LAST) begin
            cmd_err_q     <= 1'b1;
            err_timeout_q <= 1'b1;
            cmd_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      ovf_q <= ovf_d;
    end
  end

  // FIFO storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.ps2_dout;
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.cmd_done    = cmd_done_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.wr_ps2      = wr_ps2_q;
  assign bus.ps2_din     = ps2_din_q;
  assign bus.rx_valid    = !empty;
  assign bus.rx_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rx_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_cmd_ctrl
//  Purpose  : Self-checking bench for ps2_cmd_ctrl. Plays the PS/2 device
//             through the transceiver ticks and the system side through the
//             command and FIFO handshakes; expected results come from a
//             transaction-level model (reply script outcome, byte queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_cmd_ctrl;

  localparam int TMO   = 50;
  localparam int MR    = 3;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  ps2_cmd_ctrl_if bus_if ();

  ps2_cmd_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MR),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the receive FIFO contents and overflow flag
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;

  // Pulse counters seen on the falling edge
  int         wr_cnt = 0, done_cnt = 0, err_cnt = 0, din_bad = 0;
  logic [7:0] cur_cmd = 8'h00;

  always @(negedge clk) begin
    if (bus_if.wr_ps2 === 1'b1) begin
      wr_cnt++;
      if (bus_if.ps2_din !== cur_cmd) din_bad++;
    end
    if (bus_if.cmd_done === 1'b1) done_cnt++;
    if (bus_if.cmd_err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] other_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hFA || b == 8'hFE);
    return b;
  endfunction

  // One clock of receive-side stimulus; 'store' says whether the byte should
  // land in the FIFO (the model then applies the depth and pop rules).
  task automatic cycle_io(input bit rx, input logic [7:0] b, input bit store, input bit rdy);
    bit pop, clr, drop;
    bus_if.rx_done_tick = rx;
    bus_if.ps2_dout     = b;
    bus_if.rx_ready     = rdy;
    pop  = rdy && (exp_q.size() != 0);
    clr  = bus_if.clr_ovf;
    drop = 1'b0;
    tick();
    if (pop) void'(exp_q.pop_front());
    if (store) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else drop = 1'b1;
    end
    exp_ovf = (exp_ovf && !clr) || drop;
    bus_if.rx_done_tick = 1'b0;
    bus_if.rx_ready     = 1'b0;
    bus_if.ps2_dout     = 8'($urandom);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s pop%0d: rx_valid=%b rx_data=%h, want 1 %h",
                 tag, i, bus_if.rx_valid, bus_if.rx_data, exp_q[0]);
      end
      cycle_io(1'b0, 8'h00, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    n_checks++;
    if (bus_if.rx_valid !== 1'b0 || bus_if.rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL %s empty: rx_valid=%b rx_data=%h, want 0 00",
               tag, bus_if.rx_valid, bus_if.rx_data);
    end
  endtask

  // One command transaction; the device answers n_fe RESENDs then ACK, and
  // inserts n_other unrelated bytes after the first transmission.
  task automatic run_cmd(input logic [7:0] cmd, input int n_fe, input int n_other, input string tag);
    int         attempts;
    bit         exp_ok;
    logic [7:0] rsp;
    exp_ok   = (n_fe <= MR);
    attempts = exp_ok ? n_fe + 1 : MR + 1;
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; din_bad = 0; cur_cmd = cmd;

    n_checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: cmd_ready=%b, want 1", tag, bus_if.cmd_ready);
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = cmd;
    tick();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_data  = 8'($urandom);
    n_checks++;
    if (bus_if.err_timeout !== 1'b0 || bus_if.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: err_timeout=%b cmd_ready=%b, want 0 0",
               tag, bus_if.err_timeout, bus_if.cmd_ready);
    end

    for (int a = 0; a < attempts; a++) begin
      n_checks++;
      if (bus_if.wr_ps2 !== 1'b1 || bus_if.ps2_din !== cmd) begin
        n_fail++;
        $display("FAIL %s wr%0d: wr_ps2=%b ps2_din=%h, want 1 %h",
                 tag, a, bus_if.wr_ps2, bus_if.ps2_din, cmd);
      end
      repeat ($urandom_range(1, 4)) tick();
      bus_if.tx_done_tick = 1'b1;
      tick();
      bus_if.tx_done_tick = 1'b0;
      if (a == 0) begin
        for (int k = 0; k < n_other; k++) begin
          repeat ($urandom_range(0, 8)) tick();
          cycle_io(1'b1, other_byte(), 1'b1, 1'b0);
        end
      end
      repeat ($urandom_range(0, 12)) tick();
      rsp = (a < n_fe) ? 8'hFE : 8'hFA;
      cycle_io(1'b1, rsp, 1'b0, 1'b0);
    end

    n_checks++;
    if (bus_if.cmd_done !== exp_ok || bus_if.cmd_err !== !exp_ok ||
        bus_if.err_timeout !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result: done=%b err=%b tmo=%b ready=%b, want %b %b 0 1",
               tag, bus_if.cmd_done, bus_if.cmd_err, bus_if.err_timeout,
               bus_if.cmd_ready, exp_ok, !exp_ok);
    end
    repeat (2) tick();
    n_checks++;
    if (wr_cnt != attempts || done_cnt != int'(exp_ok) || err_cnt != int'(!exp_ok) ||
        din_bad != 0 || bus_if.cmd_done !== 1'b0 || bus_if.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulses: wr=%0d done=%0d err=%0d din_bad=%0d, want %0d %0d %0d 0",
               tag, wr_cnt, done_cnt, err_cnt, din_bad, attempts, int'(exp_ok), int'(!exp_ok));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.cmd_done !== 1'b0 || bus_if.cmd_err !== 1'b0 ||
        bus_if.err_timeout !== 1'b0 || bus_if.wr_ps2 !== 1'b0 || bus_if.ps2_din !== 8'h00 ||
        bus_if.rx_valid !== 1'b0 || bus_if.rx_data !== 8'h00 || bus_if.rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b done=%b err=%b tmo=%b wr=%b din=%h rxv=%b rxd=%h ovf=%b, want 1 0 0 0 0 00 0 00 0",
               bus_if.cmd_ready, bus_if.cmd_done, bus_if.cmd_err, bus_if.err_timeout,
               bus_if.wr_ps2, bus_if.ps2_din, bus_if.rx_valid, bus_if.rx_data, bus_if.rx_overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ack();
    run_cmd(8'hED, 0, 0, "ack");
    n_checks++;
    if (bus_if.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack fifo: rx_valid=%b, want 0", bus_if.rx_valid);
    end
  endtask

  task automatic test_resend();
    run_cmd(8'hFF, 2, 0, "resend");
  endtask

  task automatic test_retry_exhaust();
    run_cmd(8'hF4, MR + 1, 0, "exhaust");
  endtask

  task automatic test_timeout();
    cur_cmd = 8'hF3; err_cnt = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = 8'hF3;
    tick();
    bus_if.cmd_valid = 1'b0;
    repeat (3) tick();
    bus_if.tx_done_tick = 1'b1;
    tick();
    bus_if.tx_done_tick = 1'b0;
    repeat (TMO - 1) tick();
    n_checks++;
    if (bus_if.cmd_err !== 1'b0 || bus_if.err_timeout !== 1'b0 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout early: err=%b tmo=%b errs=%0d, want 0 0 0",
               bus_if.cmd_err, bus_if.err_timeout, err_cnt);
    end
    tick();
    n_checks++;
    if (bus_if.cmd_err !== 1'b1 || bus_if.err_timeout !== 1'b1 || bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout fire: err=%b tmo=%b ready=%b, want 1 1 1",
               bus_if.cmd_err, bus_if.err_timeout, bus_if.cmd_ready);
    end
    tick();
    n_checks++;
    if (bus_if.cmd_err !== 1'b0 || bus_if.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout sticky: err=%b tmo=%b, want 0 1", bus_if.cmd_err, bus_if.err_timeout);
    end
    // run_cmd checks err_timeout is cleared on acceptance
    run_cmd(8'hED, 0, 0, "after_tmo");
  endtask

  task automatic test_fifo_order();
    cycle_io(1'b1, 8'h1C, 1'b1, 1'b0);
    cycle_io(1'b1, 8'hF0, 1'b1, 1'b0);
    cycle_io(1'b1, 8'h1C, 1'b1, 1'b0);
    drain("order");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      cycle_io(1'b1, 8'(i), 1'b1, 1'b0);
      if (i == 8) begin
        n_checks++;
        if (bus_if.rx_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_at_full: rx_overflow=%b, want 0", bus_if.rx_overflow);
        end
      end
    end
    n_checks++;
    if (bus_if.rx_overflow !== exp_ovf || bus_if.rx_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL ovf_set: rx_overflow=%b rx_data=%h, want %b %h",
               bus_if.rx_overflow, bus_if.rx_data, exp_ovf, exp_q[0]);
    end
    bus_if.clr_ovf = 1'b1;
    cycle_io(1'b1, 8'h0A, 1'b1, 1'b0);
    bus_if.clr_ovf = 1'b0;
    n_checks++;
    if (bus_if.rx_overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL ovf_clr_vs_set: rx_overflow=%b, want %b", bus_if.rx_overflow, exp_ovf);
    end
    bus_if.clr_ovf = 1'b1;
    cycle_io(1'b0, 8'h00, 1'b0, 1'b0);
    bus_if.clr_ovf = 1'b0;
    n_checks++;
    if (bus_if.rx_overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL ovf_clear: rx_overflow=%b, want %b", bus_if.rx_overflow, exp_ovf);
    end
    cycle_io(1'b1, 8'h0B, 1'b1, 1'b1);
    n_checks++;
    if (bus_if.rx_overflow !== exp_ovf || bus_if.rx_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL full_push_pop: rx_overflow=%b rx_data=%h, want %b %h",
               bus_if.rx_overflow, bus_if.rx_data, exp_ovf, exp_q[0]);
    end
    drain("overflow");
  endtask

  task automatic test_empty_push_pop();
    cycle_io(1'b1, 8'h55, 1'b1, 1'b1);
    n_checks++;
    if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL empty_push_pop: rx_valid=%b rx_data=%h, want 1 55",
               bus_if.rx_valid, bus_if.rx_data);
    end
    drain("empty_pp");
  endtask

  task automatic test_protocol_idle();
    cycle_io(1'b1, 8'hFA, 1'b1, 1'b0);
    cycle_io(1'b1, 8'hFE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle_io(1'b1, 8'($urandom), 1'b1, 1'b0);
    drain("proto_idle");
  endtask

  task automatic test_reset_midcmd();
    cur_cmd = 8'hAB;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = 8'hAB;
    tick();
    bus_if.cmd_valid = 1'b0;
    repeat (2) tick();
    bus_if.tx_done_tick = 1'b1;
    tick();
    bus_if.tx_done_tick = 1'b0;
    cycle_io(1'b1, 8'h33, 1'b1, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_checks++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.rx_valid !== 1'b0 || bus_if.wr_ps2 !== 1'b0 ||
        bus_if.ps2_din !== 8'h00 || bus_if.cmd_done !== 1'b0 || bus_if.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid state: ready=%b rxv=%b wr=%b din=%h done=%b err=%b, want 1 0 0 00 0 0",
               bus_if.cmd_ready, bus_if.rx_valid, bus_if.wr_ps2, bus_if.ps2_din,
               bus_if.cmd_done, bus_if.cmd_err);
    end
    wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    repeat (TMO + 10) tick();
    n_checks++;
    if (wr_cnt != 0 || done_cnt != 0 || err_cnt != 0 || bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pulses: wr=%0d done=%0d err=%0d ready=%b, want 0 0 0 1",
               wr_cnt, done_cnt, err_cnt, bus_if.cmd_ready);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      repeat ($urandom_range(0, 2)) cycle_io(1'b1, 8'($urandom), 1'b1, 1'b0);
      run_cmd(8'($urandom), int'($urandom_range(0, MR + 1)), int'($urandom_range(0, 2)), "random");
      drain("random");
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus_if.cmd_valid    = 1'b0;
    bus_if.cmd_data     = 8'h00;
    bus_if.rx_ready     = 1'b0;
    bus_if.clr_ovf      = 1'b0;
    bus_if.rx_done_tick = 1'b0;
    bus_if.tx_done_tick = 1'b0;
    bus_if.ps2_dout     = 8'h00;

    test_reset();
    test_ack();
    test_resend();
    test_retry_exhaust();
    test_timeout();
    test_fifo_order();
    test_overflow();
    test_empty_push_pop();
    test_protocol_idle();
    test_reset_midcmd();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
